cache_nway: RTL and testbench

- Parametrised N-way set-associative, write-through, write-allocate data cache; one data word per line.
- Successor to the fixed 2-way cache: configurable ways, sets and widths, plus a valid/ready request handshake.
- Backing memory is reached through an external req/ack port rather than an embedded RAM instance.
- Sits between a CPU-side requester and the RAM model.

---
 rtl/cache_nway_pkg.sv | 23 ++
 rtl/cache_nway_if.sv | 36 +++
 rtl/cache_victim_sel.sv | 26 ++
 rtl/cache_nway.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_nway.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_nway_pkg.sv
// Shared types and default sizing for the N-way set-associative cache.
// Contents: FSM state enum, default parameter values and the derived
// index/tag/way widths for the default configuration.
package cache_nway_pkg;

  localparam int unsigned DEF_WAYS   = 4;
  localparam int unsigned DEF_SETS   = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;

  localparam int unsigned IDX_W = $clog2(DEF_SETS);
  localparam int unsigned TAG_W = DEF_ADDR_W - IDX_W;
  localparam int unsigned WAY_W = $clog2(DEF_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

endpackage

// File: rtl/cache_nway_if.sv
// Request/response and backing-memory signals of cache_nway.
// slave  : the cache side (accepts requests, issues memory requests).
// master : the environment side (CPU requester plus memory model).
interface cache_nway_if
  import cache_nway_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, otherwise the
// round-robin pointer with evict=1.
// Ports: valid (per-way valid bits), rr_ptr (set's pointer),
//        victim (chosen way), evict (all ways valid).
module cache_victim_sel
  import cache_nway_pkg::*;
#(
  parameter  int unsigned WAYS     = DEF_WAYS,
  localparam int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]     valid,
  input  logic [WAY_BITS-1:0] rr_ptr,
  output logic [WAY_BITS-1:0] victim,
  output logic                evict
);

  // Scanning downward leaves the lowest invalid index as the final winner.
  always_comb begin
    evict  = &valid;
    victim = rr_ptr;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid[WAY_BITS'(w)]) victim = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-through, write-allocate data cache, one word
// per line, with a valid/ready request port and an external req/ack memory
// port.
// Ports: clk, rst_n (async active-low); bus (cache_nway_if.slave) carrying
//        req_*/resp_* toward the CPU and mem_* toward backing memory.
// Optional: CACHE_NWAY_STATS_EN adds saturating stat_hits/stat_misses.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int unsigned WAYS   = DEF_WAYS,
  parameter int unsigned SETS   = DEF_SETS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_nway_if.slave        bus
`ifdef CACHE_NWAY_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
`endif
);

  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned TAG_BITS = ADDR_W - IDX_BITS;
  localparam int unsigned WAY_BITS = $clog2(WAYS);

  state_t state, state_d;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAY_BITS-1:0] rr_q    [SETS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]   data_q  [SETS][WAYS];

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  assign idx = addr_q[IDX_BITS-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_BITS];

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [DATA_W-1:0]   hit_data;
  logic [WAY_BITS-1:0] victim;
  logic                evict;

  logic                accept, we, rr_adv;
  logic [WAY_BITS-1:0] we_way;
  logic [DATA_W-1:0]   we_data;

  logic              ready_d, resp_valid_d, resp_hit_d, mem_req_d, mem_wr_d;
  logic [DATA_W-1:0] resp_data_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  // Tag compare across the set addressed by the latched request.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][WAY_BITS'(w)] && (tag_q[idx][WAY_BITS'(w)] == tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_BITS'(w);
        hit_data = data_q[idx][WAY_BITS'(w)];
      end
    end
  end

  cache_victim_sel #(.WAYS(WAYS)) u_victim (
    .valid  (valid_q[idx]),
    .rr_ptr (rr_q[idx]),
    .victim (victim),
    .evict  (evict)
  );

  // Next-state, array write port and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    we          = 1'b0;
    we_way      = hit_way;
    we_data     = wdata_q;
    rr_adv      = 1'b0;
    resp_hit_d  = bus.resp_hit;
    resp_data_d = bus.resp_data;
    mem_req_d   = bus.mem_req;
    mem_wr_d    = bus.mem_wr;
    mem_addr_d  = bus.mem_addr;
    mem_wdata_d = bus.mem_wdata;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        resp_hit_d = hit;
        if (!wr_q) begin
          if (hit) begin
            resp_data_d = hit_data;
            state_d     = RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = MEM_RD;
          end
        end else begin
          // Write hit updates in place; write miss allocates like a fill.
          we = 1'b1;
          if (!hit) begin
            we_way = victim;
            rr_adv = evict;
          end
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = MEM_WR;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          we          = 1'b1;
          we_way      = victim;
          we_data     = bus.mem_rdata;
          rr_adv      = evict;
          resp_data_d = bus.mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = RESP;
        end
      end
      MEM_WR: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_data  <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_wr     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      state          <= state_d;
      if (accept) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      bus.req_ready  <= ready_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_hit   <= resp_hit_d;
      bus.resp_data  <= resp_data_d;
      bus.mem_req    <= mem_req_d;
      bus.mem_wr     <= mem_wr_d;
      bus.mem_addr   <= mem_addr_d;
      bus.mem_wdata  <= mem_wdata_d;
    end
  end

  // Valid bits and round-robin pointers; pointer moves only on eviction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[IDX_BITS'(s)] <= '0;
        rr_q[IDX_BITS'(s)]    <= '0;
      end
    end else begin
      if (we)     valid_q[idx][we_way] <= 1'b1;
      if (rr_adv) rr_q[idx]            <= WAY_BITS'(rr_q[idx] + 1'b1);
    end
  end

  // Tag and data storage need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx][we_way]  <= tag;
      data_q[idx][we_way] <= we_data;
    end
  end

`ifdef CACHE_NWAY_STATS_EN
  // Saturating lookup counters, one event per LOOKUP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: vector table of requests with
// hand-derived hit/data expectations, a scoreboard queue popped on
// resp_valid, and hand sequences for held req_valid and mid-miss reset.
module tb_cache_nway;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_nway_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_NWAY_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  cache_nway #(.WAYS(4), .SETS(16), .DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef CACHE_NWAY_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    bit          hit;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd = 32'h0;
  int          exp_hits = 0, exp_misses = 0;
  int          mem_rises = 0, resp_cnt = 0;
  logic        mem_req_prev = 1'b0;

  // Scoreboard consumer and event counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req && !mem_req_prev) mem_rises++;
      if (bus.resp_valid) begin
        exp_t e;
        resp_cnt++;
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
          chk("resp_data", 64'(bus.resp_data), 64'(e.data));
        end
      end
    end
    mem_req_prev = bus.mem_req;
  end

  function automatic vec_t mk(bit rst, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int lat, bit hit, logic [31:0] data);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.lat = lat; v.hit = hit; v.data = data;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    last_rd = 32'h0; exp_hits = 0; exp_misses = 0;
  endtask

  // One transaction; called and returns at a negedge with the cache idle.
  task automatic do_req(input string nm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                        input bit hit, input logic [31:0] data, input bit hold);
    exp_t e;
    int cyc, mem_cyc;
    bit done, seen, ready_bad, stab_bad;
    logic [31:0] s_addr, s_wdata;
    logic s_wr;
    e.hit = hit;
    e.data = wr ? last_rd : data;
    if (!wr) last_rd = data;
    if (hit) exp_hits++; else exp_misses++;
    chk({nm, "_ready_before"}, 64'(bus.req_ready), 64'd1);
    sb_q.push_back(e);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    cyc = 0; mem_cyc = 0; done = 0; seen = 0; ready_bad = 0; stab_bad = 0;
    s_addr = '0; s_wdata = '0; s_wr = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.req_valid = 1'b0;
      bus.mem_ack = 1'b0;
      if (bus.resp_valid) begin
        done = 1;
      end else begin
        if (bus.req_ready) ready_bad = 1;
        if (bus.mem_req) begin
          if (!seen) begin
            seen = 1;
            s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_wr = bus.mem_wr;
            chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'(addr));
            chk({nm, "_mem_wr"}, 64'(bus.mem_wr), 64'(wr));
            if (wr) chk({nm, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(wdata));
          end else if (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
                       bus.mem_wr !== s_wr) begin
            stab_bad = 1;
          end
          if (mem_cyc == lat) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rdata;
          end
          mem_cyc++;
        end
      end
    end
    bus.req_valid = 1'b0;
    bus.mem_ack = 1'b0;
    chk({nm, "_resp_seen"}, 64'(done), 64'd1);
    chk({nm, "_mem_used"}, 64'(seen), 64'(wr || !hit));
    chk({nm, "_ready_low"}, 64'(ready_bad), 64'd0);
    if (seen) chk({nm, "_mem_stable"}, 64'(stab_bad), 64'd0);
    if (!wr && hit) chk({nm, "_hit_latency"}, 64'(cyc), 64'd2);
    @(negedge clk);
    chk({nm, "_resp_pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({nm, "_ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic chk_stats(input string nm);
`ifdef CACHE_NWAY_STATS_EN
    chk({nm, "_stat_hits"}, 64'(stat_hits), 64'(exp_hits));
    chk({nm, "_stat_misses"}, 64'(stat_misses), 64'(exp_misses));
`else
    if (nm.len() == 0) $display("stats disabled");
`endif
  endtask

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    int r0, m0;
    bit seen;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    //          rst wr addr     wdata     rdata        lat hit data
    vecs[0]  = mk(0, 0, 32'h10, 32'h0,    32'hDEADBEEF, 3, 0, 32'hDEADBEEF);
    vecs[1]  = mk(0, 0, 32'h10, 32'h0,    32'h0,        0, 1, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 32'h20, 32'h1234, 32'h0,        1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 32'h20, 32'h0,    32'h0,        0, 1, 32'h1234);
    vecs[4]  = mk(1, 0, 32'h00, 32'h0,    32'h100,      1, 0, 32'h100);
    vecs[5]  = mk(0, 0, 32'h10, 32'h0,    32'h110,      2, 0, 32'h110);
    vecs[6]  = mk(0, 0, 32'h20, 32'h0,    32'h120,      0, 0, 32'h120);
    vecs[7]  = mk(0, 0, 32'h30, 32'h0,    32'h130,      1, 0, 32'h130);
    vecs[8]  = mk(0, 0, 32'h40, 32'h0,    32'h140,      1, 0, 32'h140);
    vecs[9]  = mk(0, 0, 32'h00, 32'h0,    32'h200,      1, 0, 32'h200);
    vecs[10] = mk(0, 0, 32'h20, 32'h0,    32'h0,        0, 1, 32'h120);
    vecs[11] = mk(0, 0, 32'h10, 32'h0,    32'h210,      1, 0, 32'h210);
    vecs[12] = mk(0, 1, 32'h30, 32'hAAAA, 32'h0,        0, 1, 32'h0);
    vecs[13] = mk(0, 0, 32'h30, 32'h0,    32'h0,        0, 1, 32'hAAAA);
    vecs[14] = mk(0, 0, 32'h60, 32'h0,    32'h160,      1, 0, 32'h160);
    vecs[15] = mk(0, 0, 32'h40, 32'h0,    32'h0,        0, 1, 32'h140);
    vecs[16] = mk(0, 0, 32'h00, 32'h0,    32'h0,        0, 1, 32'h200);
    vecs[17] = mk(0, 0, 32'h10, 32'h0,    32'h0,        0, 1, 32'h210);
    vecs[18] = mk(0, 1, 32'h11, 32'h5555, 32'h0,        2, 0, 32'h0);
    vecs[19] = mk(0, 0, 32'h11, 32'h0,    32'h0,        0, 1, 32'h5555);
    vecs[20] = mk(0, 0, 32'h30, 32'h0,    32'h230,      1, 0, 32'h230);
    vecs[21] = mk(0, 0, 32'h40, 32'h0,    32'h240,      0, 0, 32'h240);
    vecs[22] = mk(0, 0, 32'h00, 32'h0,    32'h300,      1, 0, 32'h300);
    vecs[23] = mk(0, 0, 32'h60, 32'h0,    32'h0,        0, 1, 32'h160);

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    apply_reset();
    chk_stats("rst");

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) apply_reset();
      do_req($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].lat, vecs[i].hit, vecs[i].data, 1'b0);
    end
    chk_stats("table");

    // req_valid held through a miss: one memory request, one response.
    r0 = resp_cnt; m0 = mem_rises;
    do_req("hold", 1'b0, 32'h80, 32'h0, 32'h180, 2, 1'b0, 32'h180, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_resp_count", 64'(resp_cnt - r0), 64'd1);
    chk("hold_mem_count", 64'(mem_rises - m0), 64'd1);
    chk_stats("hold");

    // Reset while waiting for a read fill; the late ack must be ignored.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 32'h70;
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_req;
    end
    chk("rstmid_mem_req_up", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_mem_req_drop", 64'(bus.mem_req), 64'd0);
    r0 = resp_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_resp", 64'(resp_cnt - r0), 64'd0);
    chk("rstmid_mem_req_idle", 64'(bus.mem_req), 64'd0);
    chk("rstmid_ready", 64'(bus.req_ready), 64'd1);
    chk("rstmid_resp_data", 64'(bus.resp_data), 64'd0);
    sb_q.delete();
    last_rd = 32'h0; exp_hits = 0; exp_misses = 0;
    do_req("post_rst_10", 1'b0, 32'h10, 32'h0, 32'h77, 0, 1'b0, 32'h77, 1'b0);
    do_req("post_rst_70", 1'b0, 32'h70, 32'h0, 32'h78, 2, 1'b0, 32'h78, 1'b0);
    chk_stats("final");
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
